// File: rtl/datapath_sequencer.sv
// datapath_sequencer: fetch/decode/execute controller for the register-file + ALU
// datapath. Fetches 48-bit instruction words, plus an optional 32-bit constant word,
// over a req/ack handshake. It keeps the program counter and drives the datapath controls.
// Optional build macro: DATAPATH_SEQ_RETIRE_CNT_EN adds a 32-bit retire_count output.
module datapath_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            halted,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [47:0]     imem_rdata,
  output logic [2:0]      op,
  output logic            form,
  output logic [1:0]      vec,
  output logic [3:0]      A,
  output logic [3:0]      B,
  output logic [3:0]      C,
  output logic [3:0]      D,
  output logic [3:0]      Y1,
  output logic [3:0]      Y2,
  output logic [3:0]      zero_reg,
  output logic [1:0]      write,
  output logic            const_a,
  output logic [31:0]     constant,
  output logic            copy_neg,
  output logic [3:0]      copy_select,
  output logic            program_counter_inc
`ifdef DATAPATH_SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0]     retire_count
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CONST, S_EXEC, S_HALTED} state_t;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_HALT = 2'b01;
  localparam logic [1:0] CLS_JUMP = 2'b10;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [1:0]      class_q;
  logic [2:0]      op_q;
  logic            form_q;
  logic [1:0]      vec_q;
  logic [3:0]      a_q, b_q, c_q, d_q, y1_q, y2_q;
  logic [3:0]      zero_reg_q;
  logic [1:0]      write_q;
  logic            const_a_q;
  logic [31:0]     const_q;
  logic            copy_neg_q;
  logic [3:0]      copy_select_q;
  logic            fetching;
  logic            handshake;
  logic            need_const;
  logic            unused_rsvd;

  // Reserved instruction bits [47:44] carry no meaning.
  assign unused_rsvd = ^imem_rdata[47:44];

  // An ack only counts while a request is outstanding.
  assign fetching   = (state_q == S_FETCH) || (state_q == S_CONST);
  assign handshake  = fetching && imem_ack;
  // The constant word follows a JUMP, or an ALU instruction that takes its A operand from it.
  assign need_const = (imem_rdata[43:42] == CLS_JUMP) ||
                      ((imem_rdata[43:42] == CLS_ALU) && imem_rdata[36]);

  // Control sequencing, program counter and the decoded-field registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      class_q       <= CLS_ALU;
      op_q          <= '0;
      form_q        <= 1'b0;
      vec_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      y1_q          <= '0;
      y2_q          <= '0;
      zero_reg_q    <= '0;
      write_q       <= '0;
      const_a_q     <= 1'b0;
      const_q       <= '0;
      copy_neg_q    <= 1'b0;
      copy_select_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (start) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            pc_q          <= pc_q + PC_W'(1);
            op_q          <= imem_rdata[2:0];
            form_q        <= imem_rdata[3];
            vec_q         <= imem_rdata[5:4];
            a_q           <= imem_rdata[9:6];
            b_q           <= imem_rdata[13:10];
            c_q           <= imem_rdata[17:14];
            d_q           <= imem_rdata[21:18];
            y1_q          <= imem_rdata[25:22];
            y2_q          <= imem_rdata[29:26];
            zero_reg_q    <= imem_rdata[33:30];
            write_q       <= imem_rdata[35:34];
            const_a_q     <= imem_rdata[36];
            copy_neg_q    <= imem_rdata[37];
            copy_select_q <= imem_rdata[41:38];
            class_q       <= imem_rdata[43:42];
            state_q       <= need_const ? S_CONST : S_EXEC;
          end
        end
        S_CONST: begin
          if (imem_ack) begin
            pc_q    <= pc_q + PC_W'(1);
            const_q <= imem_rdata[31:0];
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (class_q == CLS_JUMP) pc_q <= PC_W'(const_q);
          state_q <= (class_q == CLS_HALT) ? S_HALTED : S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DATAPATH_SEQ_RETIRE_CNT_EN
  logic [31:0] retire_q;

  // Count every EXEC cycle, whatever the instruction class; wraps silently.
  always_ff @(posedge clk) begin
    if (rst)                    retire_q <= '0;
    else if (state_q == S_EXEC) retire_q <= retire_q + 32'd1;
  end

  assign retire_count = retire_q;
`endif

  assign busy                = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted              = (state_q == S_HALTED);
  assign imem_req            = fetching;
  assign imem_addr           = pc_q;
  assign program_counter_inc = handshake && !rst;
  assign op                  = op_q;
  assign form                = form_q;
  assign vec                 = vec_q;
  assign A                   = a_q;
  assign B                   = b_q;
  assign C                   = c_q;
  assign D                   = d_q;
  assign Y1                  = y1_q;
  assign Y2                  = y2_q;
  assign zero_reg            = zero_reg_q;
  // Register writes fire only in the single EXEC cycle of an ALU instruction.
  assign write               = ((state_q == S_EXEC) && (class_q == CLS_ALU)) ? write_q : 2'b00;
  assign const_a             = const_a_q;
  assign constant            = const_q;
  assign copy_neg            = copy_neg_q;
  assign copy_select         = copy_select_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer. A behavioural instruction memory has a
// programmable ack delay. Fetch addresses and register writes are scoreboarded through
// queues, and cycle-exact directed checks cover latency, jumps, halt/resume, reset and PC wrap.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;

  logic        busy, halted, imem_req, imem_ack, const_a, copy_neg, form, pc_inc;
  logic [15:0] imem_addr;
  logic [47:0] rdata;
  logic [2:0]  op;
  logic [1:0]  vec, write;
  logic [3:0]  A, B, C, D, Y1, Y2, zero_reg, copy_select;
  logic [31:0] constant;

  logic        busy2, halted2, imem_req2, imem_ack2, const_a2, copy_neg2, form2, pc_inc2;
  logic [3:0]  imem_addr2;
  logic [47:0] rdata2;
  logic [2:0]  op2;
  logic [1:0]  vec2, write2;
  logic [3:0]  A2, B2, C2, D2, Y1_2, Y2_2, zero_reg2, copy_select2;
  logic [31:0] constant2;

  logic [47:0] mem [0:255];
  logic [47:0] mem2 [0:15];
  int          delay = 0;
  int          wcnt = 0;
  logic        ack_auto = 1'b0;
  logic        mem_auto, ack_man;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] fq[$];
  logic [63:0] wq[$];

  always #5 clk = ~clk;

  datapath_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .halted(halted),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(rdata),
    .op(op), .form(form), .vec(vec), .A(A), .B(B), .C(C), .D(D), .Y1(Y1), .Y2(Y2),
    .zero_reg(zero_reg), .write(write), .const_a(const_a), .constant(constant),
    .copy_neg(copy_neg), .copy_select(copy_select), .program_counter_inc(pc_inc)
  );

  datapath_sequencer #(.PC_W(4), .RESET_PC(4'hF)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .halted(halted2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(rdata2),
    .op(op2), .form(form2), .vec(vec2), .A(A2), .B(B2), .C(C2), .D(D2), .Y1(Y1_2), .Y2(Y2_2),
    .zero_reg(zero_reg2), .write(write2), .const_a(const_a2), .constant(constant2),
    .copy_neg(copy_neg2), .copy_select(copy_select2), .program_counter_inc(pc_inc2)
  );

  // Memory for the main instance: ack after 'delay' wait cycles, data with the ack.
  always @(negedge clk) begin
    ack_auto = 1'b0;
    if (imem_req) begin
      if (wcnt >= delay) begin
        ack_auto = 1'b1;
        rdata    = mem[imem_addr[7:0]];
        wcnt     = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end
  assign imem_ack  = mem_auto ? ack_auto : ack_man;

  // Zero-wait memory for the narrow-PC instance.
  assign imem_ack2 = imem_req2;
  assign rdata2    = mem2[imem_addr2];

  function automatic logic [47:0] enc(input logic [1:0] cls, input logic [2:0] op_v,
                                      input logic [3:0] y1_v, input logic [1:0] wr,
                                      input logic ca);
    enc = {4'hA, cls, 4'h5, 1'b1, ca, wr, 4'h0, 4'h2, y1_v, 4'h4, 4'h3, 4'h2, 4'h1,
           2'b01, 1'b1, op_v};
  endfunction

  function automatic logic [63:0] wpack(input logic [1:0] wr, input logic [3:0] y,
                                        input logic [2:0] o, input logic [31:0] k);
    wpack = {23'd0, wr, y, o, k};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle to the sampling point and service the scoreboards.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    #1;
    if (imem_req && imem_ack) begin
      if (fq.size() == 0) chk("unexpected_fetch", {48'd0, imem_addr}, 64'hFFFF_FFFF);
      else begin
        e = fq.pop_front();
        chk("fetch_addr", {48'd0, imem_addr}, e);
      end
    end
    if (write != 2'b00) begin
      if (wq.size() == 0) chk("unexpected_write", wpack(write, Y1, op, constant), 64'hFFFF_FFFF);
      else begin
        e = wq.pop_front();
        chk("write_event", wpack(write, Y1, op, constant), e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; mem_auto = 1'b1; ack_man = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = enc(2'b11, 3'd0, 4'd0, 2'b11, 1'b0);
    for (int i = 0; i < 16; i++)  mem2[i] = enc(2'b11, 3'd0, 4'd0, 2'b11, 1'b0);
    mem[0]     = enc(2'b00, 3'd3, 4'd3, 2'b01, 1'b0);
    mem[1]     = enc(2'b01, 3'd0, 4'd0, 2'b11, 1'b0);
    mem[2]     = enc(2'b00, 3'd5, 4'd7, 2'b10, 1'b1);
    mem[3]     = {16'hFFFF, 32'hDEAD_BEEF};
    mem[4]     = enc(2'b11, 3'd0, 4'd0, 2'b11, 1'b0);
    mem[5]     = enc(2'b10, 3'd0, 4'd0, 2'b11, 1'b0);
    mem[6]     = {16'h0000, 32'h0000_0040};
    mem[8'h40] = enc(2'b00, 3'd1, 4'd9, 2'b11, 1'b0);
    mem[8'h42] = enc(2'b01, 3'd0, 4'd0, 2'b11, 1'b0);
    mem[8'h43] = enc(2'b01, 3'd0, 4'd0, 2'b11, 1'b0);
    mem2[15]   = enc(2'b00, 3'd2, 4'd1, 2'b01, 1'b0);
    mem2[0]    = enc(2'b01, 3'd0, 4'd0, 2'b11, 1'b0);

    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_write", write, 2'b00);
    chk("rst_op", op, 3'd0);
    chk("rst_constant", constant, 32'd0);
    chk("rst_pcinc", pc_inc, 1'b0);
    chk("rst_busy2", busy2, 1'b0);

    // ALU word without constant, zero-wait memory, then HALT.
    fq.push_back(64'h0); fq.push_back(64'h1);
    wq.push_back(wpack(2'b01, 4'd3, 3'd3, 32'd0));
    rst = 1'b0; start = 1'b1;
    tick();
    chk("a_req", imem_req, 1'b1);
    chk("a_addr", imem_addr, 16'h0000);
    chk("a_pcinc", pc_inc, 1'b1);
    chk("a_busy", busy, 1'b1);
    start = 1'b0;
    tick();
    chk("a_exec_write", write, 2'b01);
    chk("a_exec_y1", Y1, 4'd3);
    chk("a_exec_A", A, 4'd1);
    chk("a_exec_copysel", copy_select, 4'd5);
    chk("a_exec_pcinc", pc_inc, 1'b0);
    tick(); tick();
    chk("halt_exec_write", write, 2'b00);
    tick();
    chk("halt_halted", halted, 1'b1);
    chk("halt_busy", busy, 1'b0);

    // ALU with constant operand, 3 wait cycles on each ack; resumes at PC 2.
    fq.push_back(64'h2); fq.push_back(64'h3);
    wq.push_back(wpack(2'b10, 4'd7, 3'd5, 32'hDEAD_BEEF));
    delay = 3; start = 1'b1;
    tick();
    chk("b_req", imem_req, 1'b1);
    chk("b_addr_resume", imem_addr, 16'h0002);
    chk("b_wait_pcinc", pc_inc, 1'b0);
    start = 1'b0;
    tick(); tick(); tick();
    chk("b_fetch_ack_pcinc", pc_inc, 1'b1);
    tick();
    chk("b_const_req", imem_req, 1'b1);
    chk("b_const_addr", imem_addr, 16'h0003);
    tick(); tick(); tick();
    chk("b_const_ack_pcinc", pc_inc, 1'b1);
    tick();
    chk("b_exec_write", write, 2'b10);
    chk("b_exec_constant", constant, 32'hDEAD_BEEF);
    chk("b_exec_const_a", const_a, 1'b1);
    delay = 0;

    // NOP, JUMP to 0x40, ALU, NOP, HALT.
    fq.push_back(64'h4); fq.push_back(64'h5); fq.push_back(64'h6);
    fq.push_back(64'h40); fq.push_back(64'h41); fq.push_back(64'h42);
    wq.push_back(wpack(2'b11, 4'd9, 3'd1, 32'h40));
    tick(); tick();
    chk("nop_write", write, 2'b00);
    tick(); tick(); tick();
    chk("jmp_exec_pcinc", pc_inc, 1'b0);
    chk("jmp_exec_write", write, 2'b00);
    chk("jmp_exec_req", imem_req, 1'b0);
    chk("jmp_exec_busy", busy, 1'b1);
    tick();
    chk("jmp_target_addr", imem_addr, 16'h0040);
    chk("jmp_target_req", imem_req, 1'b1);
    repeat (6) tick();
    chk("halt2_halted", halted, 1'b1);
    chk("halt2_busy", busy, 1'b0);

    // Resume after HALT fetches the next sequential address.
    fq.push_back(64'h43);
    start = 1'b1;
    tick();
    chk("resume_addr", imem_addr, 16'h0043);
    chk("resume_pcinc", pc_inc, 1'b1);
    start = 1'b0;
    tick(); tick();
    chk("halt3_halted", halted, 1'b1);

    // Reset during an outstanding request, late ack afterwards.
    delay = 10; start = 1'b1;
    tick();
    chk("r_req_wait", imem_req, 1'b1);
    chk("r_addr_wait", imem_addr, 16'h0044);
    start = 1'b0; rst = 1'b1;
    tick();
    chk("r_req", imem_req, 1'b0);
    chk("r_busy", busy, 1'b0);
    chk("r_constant", constant, 32'd0);
    chk("r_copysel", copy_select, 4'd0);
    rst = 1'b0; mem_auto = 1'b0; ack_man = 1'b1;
    tick();
    chk("r_late_ack_pcinc", pc_inc, 1'b0);
    chk("r_late_ack_busy", busy, 1'b0);
    chk("r_late_ack_req", imem_req, 1'b0);
    ack_man = 1'b0; mem_auto = 1'b1; delay = 0;
    start = 1'b1; rst = 1'b1;
    tick();
    chk("rst_beats_start", busy, 1'b0);
    start = 1'b0; rst = 1'b0;
    fq.push_back(64'h0); fq.push_back(64'h1);
    wq.push_back(wpack(2'b01, 4'd3, 3'd3, 32'd0));
    start = 1'b1;
    tick();
    chk("r_restart_addr", imem_addr, 16'h0000);
    start = 1'b0;
    repeat (4) tick();
    chk("r_restart_halted", halted, 1'b1);

    // Narrow PC: ALU at 15, PC wraps to 0 for the next fetch.
    start2 = 1'b1;
    tick();
    chk("w_req", imem_req2, 1'b1);
    chk("w_addr15", imem_addr2, 4'hF);
    start2 = 1'b0;
    tick();
    chk("w_exec_write", write2, 2'b01);
    chk("w_exec_y1", Y1_2, 4'd1);
    tick();
    chk("w_wrap_addr", imem_addr2, 4'h0);
    chk("w_wrap_req", imem_req2, 1'b1);
    tick(); tick();
    chk("w_halted", halted2, 1'b1);

    chk("fetch_queue_drained", fq.size(), 0);
    chk("write_queue_drained", wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
